// File: rtl/jkff_monitor.sv
// Purpose : protocol checker beside a JK flip-flop; predicts next q from {j,k} and the observed q, flags mismatches.
// Latency : a bad q sampled at edge t shows as err=1 during the cycle after edge t; all outputs registered.
// Backpressure: none; en=0 suspends checking, and the first enabled edge afterwards only resyncs the prediction.
//
// Ports:
//   clk, rst          - clock (posedge), synchronous active-high reset shared with the watched flip-flop
//   en                - check enable
//   j, k, q, q_bar    - the flip-flop's inputs and outputs, as seen at the flip-flop pins
//   err               - one-cycle pulse per failing comparison
//   err_sticky        - set by the first failure, cleared only by rst
//   err_count         - failing comparisons, saturating at all-ones
//   chk_count         - comparisons performed, saturating at all-ones
//   first_err_*       - context captured at the first failure, frozen until rst
//   state             - checker FSM state: IDLE=00, RCHK=01, RUN=10
module jkff_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             q_bar,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic             first_err_valid,
    output logic [1:0]       first_err_jk,
    output logic             first_err_exp,
    output logic             first_err_q,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RCHK = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // JK characteristic equation: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic jk_next(input logic qp, input logic jv, input logic kv);
        logic nq;
        case ({jv, kv})
            2'b00:   nq = qp;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~qp;
        endcase
        return nq;
    endfunction

    state_t           state_q, state_d;
    logic             exp_q, exp_d;
    logic [1:0]       exp_jk_q, exp_jk_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] chk_count_q, chk_count_d;
    logic             fe_valid_q, fe_valid_d;
    logic [1:0]       fe_jk_q, fe_jk_d;
    logic             fe_exp_q, fe_exp_d;
    logic             fe_q_q, fe_q_d;

    logic             do_cmp;
    logic             do_pred;
    logic             mismatch;

    // A failure is either the wrong q or outputs that are not complementary.
    assign mismatch = (q != exp_q) || (q_bar != ~q);

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        exp_jk_d     = exp_jk_q;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        chk_count_d  = chk_count_q;
        fe_valid_d   = fe_valid_q;
        fe_jk_d      = fe_jk_q;
        fe_exp_d     = fe_exp_q;
        fe_q_d       = fe_q_q;
        do_cmp       = 1'b0;
        do_pred      = 1'b0;

        case (state_q)
            // RCHK compares against exp=0 left by reset: the reset check.
            ST_RCHK, ST_RUN: begin
                if (en) begin
                    do_cmp  = 1'b1;
                    do_pred = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Leaving IDLE there is no valid expectation yet, so this edge only resyncs.
            ST_IDLE: begin
                if (en) begin
                    do_pred = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_cmp) begin
            if (chk_count_q != CNT_MAX) begin
                chk_count_d = chk_count_q + CNT_W'(1);
            end
            if (mismatch) begin
                err_d        = 1'b1;
                err_sticky_d = 1'b1;
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (!fe_valid_q) begin
                    fe_valid_d = 1'b1;
                    fe_jk_d    = exp_jk_q;
                    fe_exp_d   = exp_q;
                    fe_q_d     = q;
                end
            end
        end

        // Predict from the observed q, not from exp, so a single bad q yields a single error.
        if (do_pred) begin
            exp_d    = jk_next(q, j, k);
            exp_jk_d = {j, k};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RCHK;
            exp_q        <= 1'b0;
            exp_jk_q     <= 2'b00;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            chk_count_q  <= '0;
            fe_valid_q   <= 1'b0;
            fe_jk_q      <= 2'b00;
            fe_exp_q     <= 1'b0;
            fe_q_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            exp_jk_q     <= exp_jk_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            chk_count_q  <= chk_count_d;
            fe_valid_q   <= fe_valid_d;
            fe_jk_q      <= fe_jk_d;
            fe_exp_q     <= fe_exp_d;
            fe_q_q       <= fe_q_d;
        end
    end

    assign err             = err_q;
    assign err_sticky      = err_sticky_q;
    assign err_count       = err_count_q;
    assign chk_count       = chk_count_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_jk    = fe_jk_q;
    assign first_err_exp   = fe_exp_q;
    assign first_err_q     = fe_q_q;
    assign state           = state_q;

endmodule

// File: tb/tb_jkff_monitor.sv
// Purpose : self-checking bench for jkff_monitor with an emulated JK flip-flop and fault injection.
// Latency : inputs driven at negedge, outputs sampled 1 time unit after the posedge that registers them.
// Backpressure: none; two monitors (16-bit and 2-bit counters) share one stimulus stream.
module tb_jkff_monitor;

    logic clk = 1'b0;
    logic rst, en, j, k, q, q_bar;

    logic        err, err_sticky, fe_valid, fe_exp, fe_q;
    logic [15:0] err_count, chk_count;
    logic [1:0]  fe_jk, state;

    logic        err_s, err_sticky_s, fe_valid_s, fe_exp_s, fe_q_s;
    logic [1:0]  err_count_s, chk_count_s, fe_jk_s, state_s;

    int checks   = 0;
    int failures = 0;

    // Emulated flip-flop state (the q it presents before fault injection)
    bit dut_q;

    // Reference model of the monitor, written from the checker rules
    int m_mode;          // 0 idle, 1 just reset, 2 running
    bit m_exp;
    bit [1:0] m_jk;
    int m_chk, m_errc, m_chk_s, m_errc_s;
    bit m_err, m_sticky, m_fv, m_fexp, m_fq;
    bit [1:0] m_fjk;

    always #5 clk = ~clk;

    jkff_monitor #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .err(err), .err_sticky(err_sticky), .err_count(err_count), .chk_count(chk_count),
        .first_err_valid(fe_valid), .first_err_jk(fe_jk), .first_err_exp(fe_exp),
        .first_err_q(fe_q), .state(state)
    );

    jkff_monitor #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .err(err_s), .err_sticky(err_sticky_s), .err_count(err_count_s), .chk_count(chk_count_s),
        .first_err_valid(fe_valid_s), .first_err_jk(fe_jk_s), .first_err_exp(fe_exp_s),
        .first_err_q(fe_q_s), .state(state_s)
    );

    function automatic bit fnext(input bit qp, input bit [1:0] jkv);
        if (jkv == 2'd0) return qp;
        if (jkv == 2'd1) return 1'b0;
        if (jkv == 2'd2) return 1'b1;
        return !qp;
    endfunction

    function automatic int sat_inc(input int v, input int lim);
        return (v < lim) ? v + 1 : v;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit [1:0] jkv, input bit qp, input bit qbp);
        bit bad;
        if (r) begin
            m_mode = 1; m_exp = 0; m_jk = 0; m_err = 0; m_sticky = 0;
            m_chk = 0; m_errc = 0; m_chk_s = 0; m_errc_s = 0;
            m_fv = 0; m_fjk = 0; m_fexp = 0; m_fq = 0;
        end else begin
            m_err = 0;
            if (e && m_mode != 0) begin
                m_chk   = sat_inc(m_chk, 65535);
                m_chk_s = sat_inc(m_chk_s, 3);
                bad = (qp != m_exp) || (qbp == qp);
                if (bad) begin
                    m_err    = 1;
                    m_sticky = 1;
                    m_errc   = sat_inc(m_errc, 65535);
                    m_errc_s = sat_inc(m_errc_s, 3);
                    if (!m_fv) begin
                        m_fv = 1; m_fjk = m_jk; m_fexp = m_exp; m_fq = qp;
                    end
                end
            end
            if (e) begin
                m_exp = fnext(qp, jkv);
                m_jk  = jkv;
            end
            m_mode = e ? 2 : 0;
        end
    endtask

    // fault: 0 none, 1 invert q, 2 q_bar equal to q, 3 force q low
    task automatic cycle(input bit e, input bit r, input bit [1:0] jkv, input int fault);
        bit qp, qbp;
        @(negedge clk);
        qp = dut_q;
        if (fault == 1) qp = !dut_q;
        else if (fault == 3) qp = 1'b0;
        qbp = (fault == 2) ? qp : !qp;
        rst = r; en = e; j = jkv[1]; k = jkv[0]; q = qp; q_bar = qbp;
        @(posedge clk);
        model_edge(r, e, jkv, qp, qbp);
        dut_q = r ? 1'b0 : fnext(qp, jkv);
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 1, 2'b00, 0);
        cycle(0, 1, 2'b00, 1);
        checks++; if (state !== 2'b01) begin failures++; $display("FAIL reset_state got=%b want=01", state); end
        checks++; if (err !== 1'b0 || err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b want=00", err, err_sticky); end
        checks++; if (err_count !== 16'd0 || chk_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d want=0/0", err_count, chk_count); end
        checks++; if ({fe_valid, fe_jk, fe_exp, fe_q} !== 5'b0) begin failures++; $display("FAIL reset_first_err got=%b want=00000", {fe_valid, fe_jk, fe_exp, fe_q}); end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 2'b00, 0);
            checks++; if (state !== 2'b10) begin failures++; $display("FAIL rchk_state i=%0d got=%b want=10", i, state); end
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL rchk_err i=%0d got=%b want=0", i, err); end
            checks++; if (chk_count !== 16'(i + 1)) begin failures++; $display("FAIL rchk_chk i=%0d got=%0d want=%0d", i, chk_count, i + 1); end
        end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL rchk_errc got=%0d want=0", err_count); end
    endtask

    task automatic test_jk_table();
        bit [1:0] seq [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, seq[i], 0);
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL jk_err i=%0d got=%b want=0", i, err); end
            checks++; if (chk_count !== 16'(5 + i)) begin failures++; $display("FAIL jk_chk i=%0d got=%0d want=%0d", i, chk_count, 5 + i); end
        end
        // The last expectation (q=1 after 11,11) is only checked on this edge.
        cycle(1, 0, 2'b00, 0);
        checks++; if (err !== 1'b0 || chk_count !== 16'd10) begin failures++; $display("FAIL jk_final got=err%b chk%0d want=err0 chk10", err, chk_count); end
    endtask

    task automatic test_fault();
        cycle(0, 1, 2'b00, 0);
        cycle(1, 0, 2'b10, 0);
        cycle(1, 0, 2'b00, 3);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL fault_err got=%b want=1", err); end
        checks++; if (err_count !== 16'd1 || err_sticky !== 1'b1) begin failures++; $display("FAIL fault_errc got=%0d sticky=%b want=1 sticky=1", err_count, err_sticky); end
        checks++; if ({fe_valid, fe_jk, fe_exp, fe_q} !== 5'b11010) begin failures++; $display("FAIL fault_capture got=%b want=11010", {fe_valid, fe_jk, fe_exp, fe_q}); end
        cycle(1, 0, 2'b00, 0);
        checks++; if (err !== 1'b0 || err_count !== 16'd1) begin failures++; $display("FAIL no_cascade got=err%b errc%0d want=err0 errc1", err, err_count); end
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL sticky_hold got=%b want=1", err_sticky); end
    endtask

    task automatic test_qbar_fault();
        cycle(1, 0, 2'b10, 0);
        cycle(1, 0, 2'b00, 2);
        checks++; if (err !== 1'b1 || err_count !== 16'd2) begin failures++; $display("FAIL qbar_err got=err%b errc%0d want=err1 errc2", err, err_count); end
        checks++; if ({fe_valid, fe_jk, fe_exp, fe_q} !== 5'b11010) begin failures++; $display("FAIL qbar_frozen got=%b want=11010", {fe_valid, fe_jk, fe_exp, fe_q}); end
        cycle(1, 0, 2'b00, 0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL qbar_after got=%b want=0", err); end
    endtask

    task automatic test_enable();
        int c0, e0;
        c0 = m_chk; e0 = m_errc;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 2'($urandom_range(0, 3)), 1 + (i % 2));
            checks++; if (state !== 2'b00 || err !== 1'b0) begin failures++; $display("FAIL en_off i=%0d got=st%b err%b want=st00 err0", i, state, err); end
            checks++; if (chk_count !== 16'(c0) || err_count !== 16'(e0)) begin failures++; $display("FAIL en_off_cnt i=%0d got=%0d/%0d want=%0d/%0d", i, chk_count, err_count, c0, e0); end
        end
        cycle(1, 0, 2'b11, 1);
        checks++; if (state !== 2'b10 || err !== 1'b0 || chk_count !== 16'(c0)) begin failures++; $display("FAIL resync got=st%b err%b chk%0d want=st10 err0 chk%0d", state, err, chk_count, c0); end
        cycle(1, 0, 2'b01, 0);
        checks++; if (err !== 1'b0 || chk_count !== 16'(c0 + 1)) begin failures++; $display("FAIL resume got=err%b chk%0d want=err0 chk%0d", err, chk_count, c0 + 1); end
        cycle(1, 0, 2'b00, 1);
        checks++; if (err !== 1'b1 || err_count !== 16'(e0 + 1)) begin failures++; $display("FAIL resume_err got=err%b errc%0d want=err1 errc%0d", err, err_count, e0 + 1); end
    endtask

    task automatic test_saturation();
        cycle(0, 1, 2'b00, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 2'($urandom_range(0, 3)), 1);
            checks++; if (err_s !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL sat_err i=%0d got=%b%b want=11", i, err_s, err); end
            checks++; if (err_count_s !== 2'((i < 3) ? i + 1 : 3)) begin failures++; $display("FAIL sat_errc i=%0d got=%0d want=%0d", i, err_count_s, (i < 3) ? i + 1 : 3); end
            checks++; if (chk_count_s !== 2'((i < 3) ? i + 1 : 3) || err_count !== 16'(i + 1)) begin failures++; $display("FAIL sat_chk i=%0d got=%0d/%0d want=%0d/%0d", i, chk_count_s, err_count, (i < 3) ? i + 1 : 3, i + 1); end
        end
    endtask

    task automatic test_reset_midrun();
        cycle(1, 0, 2'b11, 0);
        cycle(1, 0, 2'b10, 0);
        cycle(1, 1, 2'b10, 1);
        checks++; if (state !== 2'b01 || state_s !== 2'b01) begin failures++; $display("FAIL mid_rst_state got=%b/%b want=01/01", state, state_s); end
        checks++; if ({err, err_sticky, err_count, chk_count, fe_valid, fe_jk, fe_exp, fe_q} !== 39'b0) begin failures++; $display("FAIL mid_rst_outputs got=%h want=0", {err, err_sticky, err_count, chk_count, fe_valid, fe_jk, fe_exp, fe_q}); end
        // The pending expectation (q=1) must be gone: the next check is the reset check against 0.
        cycle(1, 0, 2'b00, 0);
        checks++; if (err !== 1'b0 || chk_count !== 16'd1) begin failures++; $display("FAIL mid_rst_discard got=err%b chk%0d want=err0 chk1", err, chk_count); end
    endtask

    task automatic test_random();
        int f;
        for (int n = 0; n < 600; n++) begin
            f = 0;
            if ($urandom_range(0, 7) == 0) f = 1;
            else if ($urandom_range(0, 15) == 0) f = 2;
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0, 2'($urandom_range(0, 3)), f);
            checks++; if (state !== 2'(m_mode) || state_s !== 2'(m_mode)) begin failures++; $display("FAIL rnd_state n=%0d got=%b/%b want=%0d", n, state, state_s, m_mode); end
            checks++; if (err !== m_err || err_s !== m_err || err_sticky !== m_sticky) begin failures++; $display("FAIL rnd_err n=%0d got=%b%b%b want=%b%b%b", n, err, err_s, err_sticky, m_err, m_err, m_sticky); end
            checks++; if (chk_count !== 16'(m_chk) || err_count !== 16'(m_errc)) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, chk_count, err_count, m_chk, m_errc); end
            checks++; if (chk_count_s !== 2'(m_chk_s) || err_count_s !== 2'(m_errc_s)) begin failures++; $display("FAIL rnd_cnt_s n=%0d got=%0d/%0d want=%0d/%0d", n, chk_count_s, err_count_s, m_chk_s, m_errc_s); end
            checks++; if ({fe_valid, fe_jk, fe_exp, fe_q} !== {m_fv, m_fjk, m_fexp, m_fq}) begin failures++; $display("FAIL rnd_capture n=%0d got=%b want=%b", n, {fe_valid, fe_jk, fe_exp, fe_q}, {m_fv, m_fjk, m_fexp, m_fq}); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; j = 1'b0; k = 1'b0; q = 1'b0; q_bar = 1'b1;
        dut_q = 1'b0;
        test_reset();
        test_jk_table();
        test_fault();
        test_qbar_fault();
        test_enable();
        test_saturation();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jkff_monitor.md
Name: jkff_monitor

Overview:
- Synchronous protocol checker that sits on the far side of a JK flip-flop DUT and watches its inputs (j, k) and outputs (q, q_bar) each clock.
- Predicts the next q from the JK characteristic equation and flags any mismatch.
- Counts checks and errors, and captures context for the first failure.
- Used in benches and as a bolt-on self-check beside jkff instances in larger designs.

Parameters:
CNT_W, 16, width of the check and error counters (both saturate at 2^CNT_W-1)

Ports:
clk  input  1  system clock; all sampling on posedge
rst  input  1  synchronous, active-high reset; same net that resets the DUT
en  input  1  check enable; 0 suspends comparisons and counting
j  input  1  DUT J input, as driven to DUT
k  input  1  DUT K input, as driven to DUT
q  input  1  DUT q output
q_bar  input  1  DUT q_bar output
err  output  1  one-cycle pulse per failing comparison
err_sticky  output  1  set on first error; cleared only by rst
err_count  output  CNT_W  number of failing comparisons, saturating
chk_count  output  CNT_W  number of comparisons performed, saturating
first_err_valid  output  1  capture registers hold data
first_err_jk  output  2  {j,k} that produced the failed expectation
first_err_exp  output  1  expected q at first failure
first_err_q  output  1  observed q at first failure
state  output  2  FSM state: IDLE=2'b00, RCHK=2'b01, RUN=2'b10

Behaviour:
- Next-state function f(qp,j,k): 00->qp, 01->0, 10->1, 11->~qp.
- Internal regs: exp (1 bit), exp_jk (2 bits).
- Reset (rst=1 at posedge, overrides all else):
  - state<=RCHK, exp<=0, exp_jk<=00.
  - err, err_sticky, err_count, chk_count, first_err_* all <=0.
  - No comparison is made on a reset edge.
- Comparison at a posedge:
  - Fail if q!=exp or q_bar!=~q.
  - Every comparison: chk_count+1 (saturating).
  - On fail: err<=1 for exactly one cycle; err_count+1 (saturating); err_sticky<=1.
  - On fail while first_err_valid=0: first_err_valid<=1, first_err_jk<=exp_jk, first_err_exp<=exp, first_err_q<=q.
  - first_err_* is frozen until rst once first_err_valid=1.
- FSM, evaluated at posedge with rst=0:
  - RCHK, en=1: compare against exp (=0, the reset check); exp<=f(q,j,k); exp_jk<={j,k}; ->RUN.
  - RCHK, en=0: no compare; ->IDLE.
  - RUN, en=1: compare against exp; exp<=f(q,j,k); exp_jk<={j,k}; stay RUN.
  - RUN, en=0: no compare; ->IDLE.
  - IDLE, en=1: no compare (resync edge); exp<=f(q,j,k); exp_jk<={j,k}; ->RUN.
  - IDLE, en=0: stay IDLE.
  - State encoding 2'b11 is illegal and goes to IDLE.
- Prediction is always from the observed q, never from exp, so one DUT error produces one err pulse and no cascade.
- Latency: a bad q sampled at edge t gives err=1 during the cycle after edge t.
- err is 0 on every edge with no comparison.
- Counters hold at all-ones on saturation; err still pulses at saturation.
- Simultaneous events:
  - rst beats en.
  - en falling at the same edge as a mismatch: no compare, no error.
- Reset mid-run discards any pending expectation.
- All outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
- Reset check, good DUT: rst=1 for 2 edges, then en=1 with j,k=00 for 4 edges -> state 01 then 10; chk_count=4, err_count=0, err never asserted.
- Full JK table, good DUT: apply 00,01,10,11,11 on consecutive edges from q=0 -> expected q sequence 0,0,1,0,1; chk_count increments by 1 per edge; err=0 throughout.
- Injected fault: DUT forced to hold q=0 on jk=10 -> err pulses exactly 1 cycle; err_count=1; err_sticky=1; first_err_jk=10, first_err_exp=1, first_err_q=0. Next edge with jk=00 and q=0 -> no error, confirming no cascade.
- q_bar fault: force q_bar=q=1 -> err pulse and err_count+1; first_err_* unchanged if already valid.
- Enable gating: en=0 for 3 edges while faults are injected -> state IDLE, counts unchanged, err=0. en=1 -> first edge is resync with no compare; comparisons resume on the edge after.
- Saturation and reset: CNT_W=2 with continuous faults -> err_count sticks at 3 while err still pulses. rst mid-run -> all outputs 0 next cycle, state=RCHK.
